// File: rtl/calc_acc_if.sv
// Calculator bus: button-style strobe plus operand/opcode in, registered display result and flags out.
interface calc_acc_if #(
   parameter int WIDTH = 8
);
   logic             valid_in;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic             err;
   logic             done;
   logic [1:0]       state;

   modport master (
      output valid_in, data_in,
      input  result, ovf, err, done, state
   );

   modport slave (
      input  valid_in, data_in,
      output result, ovf, err, done, state
   );
endinterface

// File: rtl/calc_acc.sv
// Strobe-driven three-state calculator; results registered 2 edges after the first edge seeing valid_in high, no backpressure.
// CALC_CHAIN_EN: results feed back into A and the FSM stays in S_OP (accumulator mode).
module calc_acc #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   calc_acc_if.slave bus
);
   localparam logic [1:0] S_A  = 2'd0;
   localparam logic [1:0] S_OP = 2'd1;
   localparam logic [1:0] S_B  = 2'd2;
`ifdef CALC_CHAIN_EN
   localparam logic [1:0] S_END = S_OP;
`else
   localparam logic [1:0] S_END = S_A;
`endif
   localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

   logic             s1, s2, s3, ev;
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, res_q, res_d;
   logic [2:0]       op_q, op_d, code;
   logic             ovf_q, ovf_d, err_q, err_d, done_q, done_d;
   logic [2:0]       alu_op;
   logic [2*WIDTH-1:0] ext_a, ext_b, full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign ev   = s2 & ~s3;
   assign code = bus.data_in[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         s3      <= 1'b0;
         state_q <= S_A;
         a_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         s1      <= bus.valid_in;
         s2      <= s1;
         s3      <= s2;
         state_q <= state_d;
         a_q     <= a_d;
         op_q    <= op_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_A:  if (ev) state_d = S_OP;
         S_OP: begin
            if (ev) begin
               case (code)
                  3'd0, 3'd1, 3'd2: state_d = S_B;
                  3'd3, 3'd4, 3'd5: state_d = S_END;
                  3'd6:             state_d = S_A;
                  default:          state_d = S_OP;
               endcase
            end
         end
         S_B:  if (ev) state_d = S_END;
         default: state_d = S_A;
      endcase
   end

   // Everything is evaluated at 2*WIDTH so carry, borrow and product overflow all land in the upper half.
   always_comb begin
      alu_op = (state_q == S_B) ? op_q : code;
      ext_a  = {{WIDTH{1'b0}}, a_q};
      ext_b  = {{WIDTH{1'b0}}, bus.data_in};
      case (alu_op)
         3'd0:    full = ext_a * ext_b;
         3'd1:    full = ext_a + ext_b;
         3'd2:    full = ext_a - ext_b;
         3'd3:    full = ext_a * ext_a;
         3'd4:    full = ext_a + ONE;
         3'd5:    full = ext_a - ONE;
         default: full = '0;
      endcase
      alu_res = full[WIDTH-1:0];
      alu_ovf = |full[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      a_d    = a_q;
      op_d   = op_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      err_d  = err_q;
      done_d = 1'b0;
      if (ev) begin
         case (state_q)
            S_A: begin
               a_d   = bus.data_in;
               res_d = bus.data_in;
               ovf_d = 1'b0;
               err_d = 1'b0;
            end
            S_OP: begin
               case (code)
                  3'd0, 3'd1, 3'd2: begin
                     op_d  = code;
                     res_d = {{(WIDTH-3){1'b0}}, code};
                     err_d = 1'b0;
                  end
                  3'd3, 3'd4, 3'd5: begin
                     res_d  = alu_res;
                     ovf_d  = alu_ovf;
                     err_d  = 1'b0;
                     done_d = 1'b1;
`ifdef CALC_CHAIN_EN
                     a_d    = alu_res;
`endif
                  end
                  3'd6: begin
                     a_d   = '0;
                     res_d = '0;
                     ovf_d = 1'b0;
                     err_d = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
            S_B: begin
               res_d  = alu_res;
               ovf_d  = alu_ovf;
               err_d  = 1'b0;
               done_d = 1'b1;
`ifdef CALC_CHAIN_EN
               a_d    = alu_res;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.result = res_q;
   assign bus.ovf    = ovf_q;
   assign bus.err    = err_q;
   assign bus.done   = done_q;
   assign bus.state  = state_q;
endmodule
